// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RISC-V fetch front end
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] SD = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] ALUop = 7'b0110011;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic {RUN, SQUASH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer with wrap-bit pointers; holds fetched entries or in-flight request PCs
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] rd, wr;
    assign empty = rd == wr;
    assign full = rd[AW-1:0] == wr[AW-1:0] && rd[AW] != wr[AW];
    assign count = wr - rd;
    assign head = mem[rd[AW-1:0]];
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            rd <= '0;
            wr <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
    always_ff @(posedge clock)
        if (push && !flush) mem[wr[AW-1:0]] <= push_data;
endmodule

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: PC owner issuing sequential fetches into an in-order queue with redirect squash.
// Define FETCH_LOG_EN to print request/enqueue/drop/redirect events in simulation.
module riscv_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic clock,
    input  logic reset_n,
    output logic imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic out_valid,
    input  logic out_ready,
    output logic [31:0] out_instr,
    output logic [XLEN-1:0] out_pc
);
    import riscv_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    fetch_state_t state, state_next;
    logic [XLEN-1:0] fpc, req_pc;
    logic [CW-1:0] occ, inflight, drop, drop_next;
    logic [XLEN+31:0] q_head;
    logic q_full, q_empty, pf_full, pf_empty, rsp, accept, pop;
    // responses with no tracked request (e.g. issued before a reset) are ignored
    assign rsp = imem_rsp_valid && !pf_empty;
    assign imem_req_valid = reset_n && !redirect_valid && !q_full && !pf_full
                            && ({1'b0, occ} + {1'b0, inflight} < LIMIT);
    assign imem_req_addr = fpc;
    assign accept = rsp && state == RUN && !redirect_valid;
    assign pop = out_ready && !q_empty && !redirect_valid;
    assign out_valid = !q_empty;
    assign out_pc = q_empty ? '0 : q_head[XLEN+31:32];
    assign out_instr = q_empty ? NOP_INSTR : q_head[31:0];
    always_comb begin
        drop_next = redirect_valid ? inflight - CW'(rsp) : drop - CW'(rsp && state == SQUASH);
        state_next = (drop_next != '0) ? SQUASH : RUN;
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= RUN;
            drop <= '0;
            fpc <= RESET_PC;
        end else begin
            state <= state_next;
            drop <= drop_next;
            fpc <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : imem_req_valid ? fpc + XLEN'(4) : fpc;
        end
    fetch_fifo #(.WIDTH(XLEN+32), .DEPTH(DEPTH)) u_queue (
        .clock, .reset_n, .push(accept), .pop, .flush(redirect_valid),
        .push_data({req_pc, imem_rsp_data}), .head(q_head), .full(q_full), .empty(q_empty), .count(occ)
    );
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcs (
        .clock, .reset_n, .push(imem_req_valid), .pop(rsp), .flush(1'b0),
        .push_data(fpc), .head(req_pc), .full(pf_full), .empty(pf_empty), .count(inflight)
    );
`ifdef FETCH_LOG_EN
    always @(posedge clock)
        if (reset_n) begin
            if (imem_req_valid) $display("%0t fetch req addr=%h", $time, fpc);
            if (accept) $display("%0t fetch enq pc=%h opcode=%b", $time, req_pc, imem_rsp_data[6:0]);
            if (rsp && !accept) $display("%0t fetch drop pc=%h", $time, req_pc);
            if (redirect_valid) $display("%0t fetch redirect %h -> %h", $time, fpc, redirect_pc);
        end
`else
`endif
endmodule
